// File: rtl/uart_rx_pkg.sv
// Shared UART receive types and defaults, also used by the downstream RX select/mux stage.
package uart_rx_pkg;

    localparam logic UART_IDLE_LEVEL = 1'b1;
    localparam int   UART_DATA_BITS  = 8;
    localparam int   UART_OVERSAMPLE = 16;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_e;

endpackage

// File: rtl/uart_rx_frame_if.sv
// Serial-in / byte-out bundle of the UART receive framer; UART_RX_PARITY_EN adds the parity pins.
interface uart_rx_frame_if
    import uart_rx_pkg::*;
#(
    parameter int DATA_BITS = UART_DATA_BITS,
    parameter int IDX_W     = $clog2(DATA_BITS)
);
    logic                 baud_tick_i;
    logic                 rx_i;
    logic [DATA_BITS-1:0] data_o;
    logic                 valid_o;
    logic                 frame_err_o;
    logic                 busy_o;
    logic [IDX_W-1:0]     bit_idx_o;
`ifdef UART_RX_PARITY_EN
    logic                 parity_odd_i;
    logic                 parity_err_o;

    modport master (
        input  baud_tick_i, rx_i, parity_odd_i,
        output data_o, valid_o, frame_err_o, busy_o, bit_idx_o, parity_err_o
    );
    modport slave (
        output baud_tick_i, rx_i, parity_odd_i,
        input  data_o, valid_o, frame_err_o, busy_o, bit_idx_o, parity_err_o
    );
`else
    modport master (
        input  baud_tick_i, rx_i,
        output data_o, valid_o, frame_err_o, busy_o, bit_idx_o
    );
    modport slave (
        output baud_tick_i, rx_i,
        input  data_o, valid_o, frame_err_o, busy_o, bit_idx_o
    );
`endif
endinterface

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the asynchronous serial line; both flops reset to the idle level.
module uart_rx_sync
    import uart_rx_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);
    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= UART_IDLE_LEVEL;
            sync_q <= UART_IDLE_LEVEL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;
endmodule

// File: rtl/uart_rx_frame.sv
// Oversampled UART receive framer: start detect, mid-bit LSB-first sampling, stop check, one-cycle strobes.
// Optional parity bit and check when UART_RX_PARITY_EN is defined.
module uart_rx_frame
    import uart_rx_pkg::*;
#(
    parameter int DATA_BITS  = UART_DATA_BITS,
    parameter int OVERSAMPLE = UART_OVERSAMPLE,
    parameter int IDX_W      = $clog2(DATA_BITS)
) (
    input  logic            clk,
    input  logic            rst_n,
    uart_rx_frame_if.master bus
);
    localparam int               TW        = $clog2(OVERSAMPLE);
    localparam logic [TW-1:0]    HALF_TICK = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0]    LAST_TICK = TW'(OVERSAMPLE - 1);
    localparam logic [IDX_W-1:0] LAST_BIT  = IDX_W'(DATA_BITS - 1);

    logic                 rx_s;
    logic                 rx_prev_q;
    state_e               state_q;
    logic [TW-1:0]        tick_q;
    logic [TW-1:0]        tick_d;
    logic [IDX_W-1:0]     bit_idx_q;
    logic [DATA_BITS-1:0] shreg_q;
    logic [DATA_BITS-1:0] data_q;
    logic                 valid_q;
    logic                 ferr_q;
`ifdef UART_RX_PARITY_EN
    logic                 par_q;
    logic                 perr_q;
`endif

    uart_rx_sync u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (bus.rx_i),
        .q_o   (rx_s)
    );

    assign tick_d = tick_q + TW'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_prev_q <= UART_IDLE_LEVEL;
            state_q   <= IDLE;
            tick_q    <= '0;
            bit_idx_q <= '0;
            shreg_q   <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            ferr_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_q     <= 1'b0;
            perr_q    <= 1'b0;
`endif
        end else begin
            rx_prev_q <= rx_s;
            valid_q   <= 1'b0;
            ferr_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            perr_q    <= 1'b0;
`endif
            case (state_q)
                // Only a fresh high-to-low edge starts a frame, so a held-low break stays silent.
                IDLE: begin
                    if (rx_prev_q == UART_IDLE_LEVEL && rx_s != UART_IDLE_LEVEL) begin
                        state_q <= START;
                        tick_q  <= '0;
                    end
                end
                START: begin
                    if (bus.baud_tick_i) begin
                        if (tick_q == HALF_TICK) begin
                            tick_q    <= '0;
                            bit_idx_q <= '0;
                            state_q   <= rx_s ? IDLE : DATA;
                        end else begin
                            tick_q <= tick_d;
                        end
                    end
                end
                DATA: begin
                    if (bus.baud_tick_i) begin
                        if (tick_q == LAST_TICK) begin
                            tick_q  <= '0;
                            shreg_q <= {rx_s, shreg_q[DATA_BITS-1:1]};
                            if (bit_idx_q == LAST_BIT) begin
                                bit_idx_q <= '0;
`ifdef UART_RX_PARITY_EN
                                state_q   <= PARITY;
`else
                                state_q   <= STOP;
`endif
                            end else begin
                                bit_idx_q <= bit_idx_q + IDX_W'(1);
                            end
                        end else begin
                            tick_q <= tick_d;
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (bus.baud_tick_i) begin
                        if (tick_q == LAST_TICK) begin
                            tick_q  <= '0;
                            par_q   <= rx_s;
                            state_q <= STOP;
                        end else begin
                            tick_q <= tick_d;
                        end
                    end
                end
`endif
                STOP: begin
                    if (bus.baud_tick_i) begin
                        if (tick_q == LAST_TICK) begin
                            tick_q  <= '0;
                            state_q <= IDLE;
                            if (rx_s) begin
                                data_q  <= shreg_q;
                                valid_q <= 1'b1;
`ifdef UART_RX_PARITY_EN
                                // XOR over data and parity bit is 1 for odd parity.
                                perr_q  <= (^shreg_q ^ par_q) ^ bus.parity_odd_i;
`endif
                            end else begin
                                ferr_q <= 1'b1;
                            end
                        end else begin
                            tick_q <= tick_d;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.data_o      = data_q;
    assign bus.valid_o     = valid_q;
    assign bus.frame_err_o = ferr_q;
    assign bus.busy_o      = (state_q != IDLE);
    assign bus.bit_idx_o   = bit_idx_q;
`ifdef UART_RX_PARITY_EN
    assign bus.parity_err_o = perr_q;
`endif
endmodule

// File: tb/tb_uart_rx_frame.sv
// Scoreboard bench for uart_rx_frame: frame-level serial driver, queue of expected strobes, decoupled monitor.
module tb_uart_rx_frame;
    localparam int DB = 8;
    localparam int OS = 16;

    typedef struct {
        bit         is_err;
        logic [7:0] data;
        bit         perr;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    int         n_cmp = 0;
    int         n_err = 0;
    int         tick_div = 4;
    int         tick_cnt_tb = 0;
    logic [7:0] model_last = '0;
    exp_t       exp_q[$];
    exp_t       m_e;
    logic [2:0] idx_log[$];
    logic [2:0] idx_last = '0;
    bit         log_en = 1'b0;

    uart_rx_frame_if #(.DATA_BITS(DB), .IDX_W(3)) bus ();

    uart_rx_frame #(.DATA_BITS(DB), .OVERSAMPLE(OS), .IDX_W(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial forever #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Free-running oversample tick, one pulse every tick_div cycles (1 = back-to-back).
    initial begin
        bus.baud_tick_i = 1'b0;
        forever begin
            @(negedge clk);
            if (tick_cnt_tb >= tick_div - 1) begin
                bus.baud_tick_i = 1'b1;
                tick_cnt_tb = 0;
            end else begin
                bus.baud_tick_i = 1'b0;
                tick_cnt_tb++;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && (bus.valid_o || bus.frame_err_o)) begin
                chk("pulse_exclusive", 32'(bus.valid_o & bus.frame_err_o), 0);
                if (exp_q.size() == 0) begin
                    chk("unexpected_pulse", 32'(bus.valid_o | bus.frame_err_o), 0);
                end else begin
                    m_e = exp_q.pop_front();
                    chk("pulse_is_frame_err", 32'(bus.frame_err_o), 32'(m_e.is_err));
                    chk("data_o", 32'(bus.data_o), 32'(m_e.data));
`ifdef UART_RX_PARITY_EN
                    chk("parity_err_o", 32'(bus.parity_err_o), 32'(m_e.perr));
`endif
                end
            end
`ifdef UART_RX_PARITY_EN
            if (rst_n && bus.parity_err_o && !bus.valid_o)
                chk("parity_without_valid", 32'(bus.parity_err_o & ~bus.valid_o), 0);
`endif
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (log_en && bus.bit_idx_o != idx_last) idx_log.push_back(bus.bit_idx_o);
            idx_last = bus.bit_idx_o;
        end
    end

    task automatic wait_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            while (!bus.baud_tick_i) @(posedge clk);
        end
        @(negedge clk);
    endtask

    task automatic drive_bit(input logic v);
        bus.rx_i = v;
        wait_ticks(OS);
    endtask

    // Reference: a good stop bit delivers the byte; a bad one reports an error and keeps the last good byte.
    task automatic send_frame(input logic [7:0] b, input bit stop_ok, input bit pbit);
        exp_t e;
        int   ones;
        ones     = $countones(b) + int'(pbit);
        e.is_err = !stop_ok;
        e.data   = stop_ok ? b : model_last;
        e.perr   = 1'b0;
`ifdef UART_RX_PARITY_EN
        e.perr   = stop_ok && (bus.parity_odd_i ? (ones % 2 == 0) : (ones % 2 == 1));
`endif
        if (stop_ok) model_last = b;
        exp_q.push_back(e);
        drive_bit(1'b0);
        for (int i = 0; i < DB; i++) drive_bit(b[i]);
`ifdef UART_RX_PARITY_EN
        drive_bit(pbit);
`endif
        drive_bit(stop_ok);
        if (!stop_ok) drive_bit(1'b1);
        bus.rx_i = 1'b1;
    endtask

    task automatic wait_drain(input string name);
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < 4000) begin
            @(negedge clk);
            k++;
        end
        chk(name, exp_q.size(), 0);
    endtask

    task automatic chk_quiet_outputs(input string tag);
        chk({tag, "_data"}, 32'(bus.data_o), 0);
        chk({tag, "_valid"}, 32'(bus.valid_o), 0);
        chk({tag, "_ferr"}, 32'(bus.frame_err_o), 0);
        chk({tag, "_busy"}, 32'(bus.busy_o), 0);
        chk({tag, "_bit_idx"}, 32'(bus.bit_idx_o), 0);
    endtask

    initial begin
        bit stop_ok;
        bit pbit;
        int gap;
        int divs[4];
        divs = '{1, 2, 3, 5};
        bus.rx_i = 1'b1;
`ifdef UART_RX_PARITY_EN
        bus.parity_odd_i = 1'b0;
`endif
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk_quiet_outputs("reset");
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        idx_log.delete();
        log_en = 1'b1;
        send_frame(8'hA5, 1'b1, 1'b0);
        log_en = 1'b0;
        wait_drain("drain_A5");
        chk("bit_idx_change_count", idx_log.size(), 8);
        foreach (idx_log[i]) chk("bit_idx_sequence", 32'(idx_log[i]), (i + 1) % 8);

        send_frame(8'h3C, 1'b1, 1'b0);
        send_frame(8'hC3, 1'b1, 1'b1);
        wait_drain("drain_back_to_back");

        send_frame(8'h55, 1'b0, 1'b0);
        wait_drain("drain_bad_stop");
        chk("data_kept_after_ferr", 32'(bus.data_o), 32'h0000_00C3);

        bus.rx_i = 1'b0;
        wait_ticks(4);
        chk("glitch_busy_high", 32'(bus.busy_o), 1);
        bus.rx_i = 1'b1;
        wait_ticks(OS);
        chk("glitch_busy_dropped", 32'(bus.busy_o), 0);

        drive_bit(1'b0);
        for (int i = 0; i < 3; i++) drive_bit(1'b1);
        wait_ticks(5);
        rst_n = 1'b0;
        model_last = '0;
        #1;
        chk_quiet_outputs("mid_frame_reset");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        wait_ticks(2 * OS);
        send_frame(8'h12, 1'b1, 1'b0);
        wait_drain("drain_after_reset");

`ifdef UART_RX_PARITY_EN
        bus.parity_odd_i = 1'b0;
        send_frame(8'h07, 1'b1, 1'b0);
        wait_drain("drain_parity_err");
`endif

        for (int n = 0; n < 24; n++) begin
            tick_div = divs[$urandom_range(0, 3)];
            stop_ok  = ($urandom_range(0, 9) != 0);
            pbit     = 1'($urandom);
`ifdef UART_RX_PARITY_EN
            bus.parity_odd_i = 1'($urandom);
`endif
            send_frame(8'($urandom), stop_ok, pbit);
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) drive_bit(1'b1);
        end
        wait_drain("drain_random");
        chk("final_data_o", 32'(bus.data_o), 32'(model_last));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/uart_rx_frame.md
Name: uart_rx_frame

Overview:
- Oversampled UART receive framer. Synchronises the serial line, detects the start bit, samples data bits mid-period LSB first, checks the stop bit and emits a byte with a one-cycle valid strobe.
- Sits directly upstream of the RX select/mux stage.
- Exports its bit-index counter (bit_idx_o), which drives that stage's 3-bit select.

Parameters:
- DATA_BITS, 8, data bits per frame (5..8).
- OVERSAMPLE, 16, baud_tick_i pulses per bit period (even, >=4).
- IDX_W, $clog2(DATA_BITS), width of bit_idx_o (3 at default).

Ports:
- clk  in  1  single system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- baud_tick_i  in  1  one-cycle pulse at OVERSAMPLE x baud rate.
- rx_i  in  1  asynchronous serial line, idle high.
- data_o  out  DATA_BITS  last good byte received.
- valid_o  out  1  one-cycle pulse; data_o is new.
- frame_err_o  out  1  one-cycle pulse on bad stop bit.
- busy_o  out  1  high in any state except IDLE.
- bit_idx_o  out  IDX_W  index of the next data bit to sample; 0 outside DATA.

Behaviour:
- Reset (async assert, sync deassert handled upstream): state=IDLE, all outputs 0. Synchroniser flops reset to 1 (line idle).
- rx_i passes through a 2-FF synchroniser; the FSM sees rx_s with 2 clk of latency.
- A sample counter (tick_cnt) advances only on cycles where baud_tick_i=1.

State machine:
- IDLE: on rx_s=0 while the previous rx_s=1 (falling edge), go to START with tick_cnt=0.
- START: when tick_cnt reaches OVERSAMPLE/2-1 on a tick, re-sample rx_s.
  - rx_s=0: go to DATA with tick_cnt=0 and bit_idx=0.
  - rx_s=1: false start; return to IDLE with no pulse.
- DATA: every OVERSAMPLE ticks, shift rx_s into the shift register MSB and shift right, so LSB-first arrival lands correctly.
  - bit_idx increments after each sample.
  - After the sample at bit_idx=DATA_BITS-1, go to STOP; bit_idx wraps to 0.
- STOP: sample after OVERSAMPLE ticks.
  - rx_s=1: data_o <= shift register; valid_o=1 for exactly one cycle; go to IDLE.
  - rx_s=0: frame_err_o=1 for one cycle; data_o unchanged; go to IDLE.
  - IDLE then waits for a fresh high-to-low edge, so a break (line held low) produces no further frames.

Latency and edge cases:
- valid_o asserts on the clk after the stop-bit mid-sample tick.
- valid_o and frame_err_o are mutually exclusive and never asserted together.
- baud_tick_i is ignored in IDLE.
- Edges on rx_i between sample points are ignored.
- A reset mid-frame aborts immediately: no pulse; data_o returns to 0.
- Ticks arriving on back-to-back cycles are legal; each counts once.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- When defined:
  - A PARITY state is inserted between DATA and STOP.
  - An extra input parity_odd_i (1=odd, 0=even) selects parity sense.
  - An extra output parity_err_o pulses for one cycle in the same cycle valid_o would pulse. valid_o is still asserted; data_o is still updated.
  - On a frame error, frame_err_o takes priority and parity_err_o stays 0.
- When undefined: no PARITY state, no parity ports; frame length is 1+DATA_BITS+1 bits.

Decomposition:
- Package uart_rx_pkg:
  - state enum (IDLE, START, DATA, PARITY, STOP), 3 bits;
  - localparam UART_IDLE_LEVEL=1'b1;
  - default DATA_BITS/OVERSAMPLE constants shared with the mux stage.
- Sub-module uart_rx_sync: 2-FF synchroniser with async active-low reset to 1.
- Tick counter, bit counter, shift register and FSM all stay in uart_rx_frame.

Test Plan:
- Byte 0xA5 at OVERSAMPLE=16, clean line -> one valid_o pulse; data_o=0xA5; bit_idx_o stepped 0..7 during DATA; frame_err_o=0.
- 0x3C then 0xC3 back-to-back with a one-bit stop -> two valid_o pulses; data_o=0x3C then 0xC3; no errors.
- 0x55 with the stop bit driven low -> frame_err_o pulse; valid_o never asserts; data_o keeps its previous value.
- Glitch: rx_i low for 4 ticks, then high -> FSM returns to IDLE from START; busy_o drops; no pulses.
- Reset asserted after 3 data bits of 0xFF -> outputs 0 immediately; a following 0x12 is received correctly.
- UART_RX_PARITY_EN, even parity, 0x07 sent with parity bit 0 (wrong) -> valid_o and parity_err_o pulse together; data_o=0x07.
